// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared states, mode encodings and LED end patterns for the sweep controller
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [1:0]  MODE_RIGHT  = 2'b00;
  localparam logic [1:0]  MODE_LEFT   = 2'b01;
  localparam logic [1:0]  MODE_BOUNCE = 2'b10;

  localparam logic [15:0] LED_MSB = 16'h8000;
  localparam logic [15:0] LED_LSB = 16'h0001;

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing a one-cycle step tick with runtime-selectable period
module led_tick_gen #(
  parameter int FAST_DIV = 16777216,
  parameter int SLOW_DIV = 134217728,
  parameter int CNT_W    = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  input  logic i_speed,
  output logic o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;

  assign w_last = i_speed ? CNT_W'(SLOW_DIV - 1) : CNT_W'(FAST_DIV - 1);

  // A clear in the same cycle restarts the period, so it also suppresses the tick.
  assign o_tick = i_en && !i_clr && (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == w_last) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_sweep_controller.sv
// rtl/led_sweep_controller.sv - one-hot 16-LED sweep sequencer with start/pause/resume/abort control
module led_sweep_controller
  import led_ctrl_pkg::*;
#(
  parameter int FAST_DIV = 16777216,
  parameter int SLOW_DIV = 134217728,
  parameter int SWEEPS   = 4,
  parameter int CNT_W    = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        speed,
  input  logic [1:0]  mode,
  output logic [15:0] led,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] SWEEP_LAST = 16'(SWEEPS - 1);

  state_t      r_state;
  logic [15:0] r_led;
  logic        r_dir;
  logic [1:0]  r_mode;
  logic [15:0] r_sweep_cnt;
  logic        r_done;
  logic        r_speed_q;

  state_t      w_state_nx;
  logic [15:0] w_led_nx;
  logic        w_dir_nx;
  logic [1:0]  w_mode_nx;
  logic [15:0] w_sweep_cnt_nx;
  logic        w_done_nx;
  logic        w_start_run;
  logic        w_tick;
  logic [15:0] w_step_led;
  logic        w_step_dir;
  logic        w_wrap;
  logic        w_last_sweep;

  led_tick_gen #(
    .FAST_DIV (FAST_DIV),
    .SLOW_DIV (SLOW_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .i_en    (r_state == RUN),
    .i_clr   (w_start_run || (speed != r_speed_q)),
    .i_speed (speed),
    .o_tick  (w_tick)
  );

  // r_dir: 0 = moving right (towards LSB), 1 = moving left.
  always_comb begin
    w_step_led = r_led;
    w_step_dir = r_dir;
    w_wrap     = 1'b0;
    case (r_mode)
      MODE_LEFT: begin
        if (r_led == LED_MSB) begin
          w_step_led = LED_LSB;
          w_wrap     = 1'b1;
        end else begin
          w_step_led = r_led << 1;
        end
      end
      MODE_BOUNCE: begin
        if (!r_dir) begin
          if (r_led == LED_LSB) begin
            w_step_dir = 1'b1;
            w_step_led = 16'h0002;
          end else begin
            w_step_led = r_led >> 1;
          end
        end else if (r_led == LED_MSB) begin
          w_step_dir = 1'b0;
          w_step_led = 16'h4000;
          w_wrap     = 1'b1;
        end else begin
          w_step_led = r_led << 1;
        end
      end
      default: begin
        if (r_led == LED_LSB) begin
          w_step_led = LED_MSB;
          w_wrap     = 1'b1;
        end else begin
          w_step_led = r_led >> 1;
        end
      end
    endcase
  end

  assign w_last_sweep = (SWEEPS != 0) && (r_sweep_cnt == SWEEP_LAST);

  always_comb begin
    w_state_nx     = r_state;
    w_led_nx       = r_led;
    w_dir_nx       = r_dir;
    w_mode_nx      = r_mode;
    w_sweep_cnt_nx = r_sweep_cnt;
    w_done_nx      = 1'b0;
    w_start_run    = 1'b0;
    case (r_state)
      IDLE: begin
        w_led_nx = LED_MSB;
        if (start && !stop) begin
          w_start_run    = 1'b1;
          w_state_nx     = RUN;
          w_mode_nx      = (mode == MODE_LEFT || mode == MODE_BOUNCE) ? mode : MODE_RIGHT;
          w_led_nx       = (mode == MODE_LEFT) ? LED_LSB : LED_MSB;
          w_dir_nx       = (mode == MODE_LEFT);
          w_sweep_cnt_nx = '0;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_nx = PAUSED;
        end else if (w_tick) begin
          if (w_wrap && w_last_sweep) begin
            w_state_nx = IDLE;
            w_led_nx   = LED_MSB;
            w_done_nx  = 1'b1;
          end else begin
            w_led_nx = w_step_led;
            w_dir_nx = w_step_dir;
            if (w_wrap && r_sweep_cnt != 16'hFFFF) begin
              w_sweep_cnt_nx = r_sweep_cnt + 16'd1;
            end
          end
        end
      end
      PAUSED: begin
        if (stop) begin
          w_state_nx = IDLE;
          w_led_nx   = LED_MSB;
        end else if (start) begin
          w_state_nx = RUN;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_led_nx   = LED_MSB;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_led       <= LED_MSB;
      r_dir       <= 1'b0;
      r_mode      <= MODE_RIGHT;
      r_sweep_cnt <= '0;
      r_done      <= 1'b0;
      r_speed_q   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_led       <= w_led_nx;
      r_dir       <= w_dir_nx;
      r_mode      <= w_mode_nx;
      r_sweep_cnt <= w_sweep_cnt_nx;
      r_done      <= w_done_nx;
      r_speed_q   <= speed;
    end
  end

  assign led  = r_led;
  assign busy = (r_state != IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_led_sweep_controller.sv
// tb/tb_led_sweep_controller.sv - randomized and scenario stimulus checked every cycle against a position-based model
module tb_led_sweep_controller;

  localparam int FAST = 4;
  localparam int SLOW = 8;
  localparam int NSW  = 2;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        speed = 1'b0;
  logic [1:0]  mode  = 2'b00;
  logic [15:0] led;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  // Model: LED as a bit position, state 0=idle 1=run 2=paused, phase = cycles since last tick.
  int m_st, m_pos, m_dir, m_mode, m_sw, m_ph;
  bit m_done, m_prev_spd;

  always #5 clk = ~clk;

  led_sweep_controller #(
    .FAST_DIV (FAST),
    .SLOW_DIV (SLOW),
    .SWEEPS   (NSW),
    .CNT_W    (27)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .speed (speed),
    .mode  (mode),
    .led   (led),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  div;
    bit  chg, tick, go, comp;
    if (rst) begin
      m_st = 0; m_pos = 15; m_dir = 0; m_mode = 0; m_sw = 0; m_ph = 0;
      m_done = 0; m_prev_spd = 0;
      return;
    end
    div  = speed ? SLOW : FAST;
    chg  = (speed != m_prev_spd);
    tick = (m_st == 1) && !chg && (m_ph + 1 == div);
    go   = (m_st == 0) && start && !stop;
    if (go || chg) m_ph = 0;
    else if (m_st == 1) m_ph = (m_ph + 1) % div;
    m_done = 0;
    comp   = 0;
    case (m_st)
      0: if (go) begin
        m_mode = (mode == 2'd3) ? 0 : int'(mode);
        m_pos  = (m_mode == 1) ? 0 : 15;
        m_dir  = (m_mode == 1) ? 1 : 0;
        m_sw   = 0;
        m_st   = 1;
      end
      1: begin
        if (stop) m_st = 2;
        else if (tick) begin
          if (m_mode == 1) begin
            if (m_pos == 15) begin m_pos = 0; comp = 1; end else m_pos++;
          end else if (m_mode == 2) begin
            if (m_dir == 0) begin
              if (m_pos == 0) begin m_pos = 1; m_dir = 1; end else m_pos--;
            end else begin
              if (m_pos == 15) begin m_pos = 14; m_dir = 0; comp = 1; end else m_pos++;
            end
          end else begin
            if (m_pos == 0) begin m_pos = 15; comp = 1; end else m_pos--;
          end
          if (comp) begin
            if (m_sw == NSW - 1) begin
              m_st = 0; m_pos = 15; m_done = 1;
            end else begin
              m_sw++;
            end
          end
        end
      end
      default: begin
        if (stop) begin m_st = 0; m_pos = 15; end
        else if (start) m_st = 1;
      end
    endcase
    m_prev_spd = speed;
  endtask

  task automatic cyc(input bit s, input bit p, input bit r);
    start = s; stop = p; rst = r;
    @(posedge clk);
    model_edge();
    #1;
    check("led",  led, 16'(1 << m_pos));
    check("busy", {15'd0, busy}, 16'(m_st != 0));
    check("done", {15'd0, done}, 16'(m_done));
    start = 1'b0; stop = 1'b0; rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  initial begin
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 1'($urandom % 2), 0);

    mode = 2'b00; speed = 1'b0;
    cyc(1, 0, 0);
    run(140);

    mode = 2'b10;
    cyc(1, 0, 0);
    run(260);

    mode = 2'b01;
    cyc(1, 0, 0);
    run(20);
    cyc(0, 1, 0);
    run(20);
    cyc(1, 0, 0);
    run(6);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    run(4);

    mode = 2'b11;
    cyc(1, 0, 0);
    run(9);
    speed = 1'b1;
    run(30);
    cyc(1, 1, 0);
    run(5);
    cyc(1, 0, 0);
    run(20);
    speed = 1'b0;
    run(6);
    cyc(0, 1, 0);
    cyc(0, 1, 0);

    mode = 2'b00;
    cyc(1, 0, 0);
    run(127);
    cyc(0, 0, 1);
    run(3);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 40 == 0) speed = ~speed;
      mode = 2'($urandom % 4);
      cyc(1'($urandom % 12 == 0), 1'($urandom % 25 == 0), 1'($urandom % 500 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
